// File: rtl/cfg_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_cmd_pkg
// Purpose  : Shared definitions for the configuration-command dispatcher:
//            FSM state encoding, error codes and command-word field offsets.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cfg_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_DECODE  = 3'd2,
    S_DELIVER = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_BAD_CHANNEL  = 2'd1;
  localparam logic [1:0] ERR_BYTE_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RDY_TIMEOUT  = 2'd3;

  // Command word layout, MSB first: channel | address | data.
  function automatic int ch_msb(input int w);
    return w - 1;
  endfunction

  function automatic int addr_msb(input int w, input int ch_bits);
    return w - ch_bits - 1;
  endfunction

  function automatic int data_msb(input int w, input int ch_bits, input int addr_width);
    return w - ch_bits - addr_width - 1;
  endfunction

  // Counter width able to hold 0 .. limit-1 (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : cfg_timeout_counter
// Purpose  : Loadable / clearable up-counter with terminal-count flag.
//            tc is high while the count equals LIMIT-1, i.e. on the LIMIT-th
//            counted cycle. LIMIT = 0 disables the terminal count entirely.
// Ports    : clk, rst_n        - clock, async active-low reset
//            clr               - synchronous clear (highest priority)
//            load, load_val    - synchronous load
//            inc               - count enable
//            tc                - terminal count reached
// Revision : 1.0 - initial release
// ============================================================================
module cfg_timeout_counter #(
  parameter int LIMIT = 1000,
  parameter int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  output logic          tc
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  generate
    if (LIMIT > 0) begin : g_limited
      assign tc = (r_count == CW'(LIMIT - 1));
    end else begin : g_unlimited
      assign tc = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cfg_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : cfg_cmd_dispatcher
// Purpose  : Pops bytes from a first-word-fall-through RX FIFO, assembles
//            BYTES_PER_CMD-byte command words (MSB byte first), decodes them
//            into channel / address / data and delivers each one to a target
//            over a per-channel valid/ready handshake. Byte-gap and ready
//            timeouts, error reporting and command/error counters included.
// Ports    : clk, rst_n              - clock, async active-low reset
//            Empty, RXD_Data, Rd_En  - RX FIFO interface (pop captures head)
//            C_Addr, C_Data          - shared target address / data
//            C_Valid, C_Rdy          - one-hot per-channel handshake
//            Done_Valid, Done_Ch     - accepted-command pulse and channel
//            Error_Valid, Error_Code - error pulse and last error code
//            Cmd_Count, Err_Count    - accepted (wraps) / errors (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module cfg_cmd_dispatcher
  import cfg_cmd_pkg::*;
#(
  parameter int BYTE_WIDTH    = 8,
  parameter int BYTES_PER_CMD = 2,
  parameter int NUM_CH        = 3,
  parameter int CH_BITS       = 2,
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 10,
  parameter int BYTE_TIMEOUT  = 1000,
  parameter int RDY_TIMEOUT   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Empty,
  input  logic [BYTE_WIDTH-1:0] RXD_Data,
  output logic                  Rd_En,
  output logic [ADDR_WIDTH-1:0] C_Addr,
  output logic [DATA_WIDTH-1:0] C_Data,
  output logic [NUM_CH-1:0]     C_Valid,
  input  logic [NUM_CH-1:0]     C_Rdy,
  output logic                  Done_Valid,
  output logic [CH_BITS-1:0]    Done_Ch,
  output logic                  Error_Valid,
  output logic [1:0]            Error_Code,
  output logic [15:0]           Cmd_Count,
  output logic [7:0]            Err_Count
);

  localparam int c_w        = BYTE_WIDTH * BYTES_PER_CMD;
  localparam int c_ch_msb   = ch_msb(c_w);
  localparam int c_addr_msb = addr_msb(c_w, CH_BITS);
  localparam int c_data_msb = data_msb(c_w, CH_BITS, ADDR_WIDTH);
  localparam int c_bcw      = $clog2(BYTES_PER_CMD + 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [c_w-1:0]        r_word;
  logic [c_w-1:0]        w_word_shifted;
  logic [c_bcw-1:0]      r_byte_cnt;
  logic [CH_BITS-1:0]    r_ch;

  logic [ADDR_WIDTH-1:0] r_c_addr;
  logic [DATA_WIDTH-1:0] r_c_data;
  logic [NUM_CH-1:0]     r_c_valid;
  logic                  r_done_valid;
  logic [CH_BITS-1:0]    r_done_ch;
  logic                  r_error_valid;
  logic [1:0]            r_error_code;
  logic [15:0]           r_cmd_count;
  logic [7:0]            r_err_count;

  logic [CH_BITS-1:0]    w_ch;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NUM_CH-1:0]     w_ch_onehot;
  logic                  w_bad_ch;

  logic                  w_pop;
  logic                  w_load_cmd;
  logic                  w_xfer;
  logic                  w_err;
  logic [1:0]            w_err_code;
  logic                  w_byte_clr;
  logic                  w_byte_inc;
  logic                  w_byte_tc;
  logic                  w_rdy_clr;
  logic                  w_rdy_inc;
  logic                  w_rdy_tc;

  // ---------------------------------------------------------------- decode
  assign w_ch        = r_word[c_ch_msb -: CH_BITS];
  assign w_addr      = r_word[c_addr_msb -: ADDR_WIDTH];
  assign w_data      = r_word[c_data_msb:0];
  assign w_ch_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << w_ch;
  assign w_bad_ch    = (32'(w_ch) >= NUM_CH);

  // New bytes enter at the bottom; after BYTES_PER_CMD pops the first byte
  // has reached the top, and any stale partial word is fully shifted out.
  generate
    if (BYTES_PER_CMD == 1) begin : g_single_byte
      assign w_word_shifted = RXD_Data;
    end else begin : g_multi_byte
      assign w_word_shifted = {r_word[c_w-BYTE_WIDTH-1:0], RXD_Data};
    end
  endgenerate

  // ---------------------------------------------------------------- timers
  cfg_timeout_counter #(
    .LIMIT (BYTE_TIMEOUT)
  ) u_byte_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_byte_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (w_byte_inc),
    .tc       (w_byte_tc)
  );

  cfg_timeout_counter #(
    .LIMIT (RDY_TIMEOUT)
  ) u_rdy_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_rdy_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (w_rdy_inc),
    .tc       (w_rdy_tc)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_cmd  = 1'b0;
    w_xfer      = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_NONE;
    w_byte_clr  = 1'b0;
    w_byte_inc  = 1'b0;
    w_rdy_clr   = 1'b0;
    w_rdy_inc   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_byte_clr = 1'b1;
        w_rdy_clr  = 1'b1;
        if (!Empty) begin
          w_pop       = 1'b1;
          w_state_nxt = (BYTES_PER_CMD == 1) ? S_DECODE : S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (!Empty) begin
          w_pop      = 1'b1;
          w_byte_clr = 1'b1;
          if (r_byte_cnt == c_bcw'(BYTES_PER_CMD - 1)) begin
            w_state_nxt = S_DECODE;
          end
        end else if (w_byte_tc) begin
          w_err       = 1'b1;
          w_err_code  = ERR_BYTE_TIMEOUT;
          w_state_nxt = S_ERR;
        end else begin
          w_byte_inc = 1'b1;
        end
      end

      S_DECODE: begin
        w_rdy_clr = 1'b1;
        if (w_bad_ch) begin
          w_err       = 1'b1;
          w_err_code  = ERR_BAD_CHANNEL;
          w_state_nxt = S_ERR;
        end else begin
          w_load_cmd  = 1'b1;
          w_state_nxt = S_DELIVER;
        end
      end

      S_DELIVER: begin
        // Ready in the timeout cycle still completes the transfer.
        if ((r_c_valid & C_Rdy) != '0) begin
          w_xfer      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rdy_tc) begin
          w_err       = 1'b1;
          w_err_code  = ERR_RDY_TIMEOUT;
          w_state_nxt = S_ERR;
        end else begin
          w_rdy_inc = 1'b1;
        end
      end

      S_ERR: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word        <= '0;
      r_byte_cnt    <= '0;
      r_ch          <= '0;
      r_c_addr      <= '0;
      r_c_data      <= '0;
      r_c_valid     <= '0;
      r_done_valid  <= 1'b0;
      r_done_ch     <= '0;
      r_error_valid <= 1'b0;
      r_error_code  <= ERR_NONE;
      r_cmd_count   <= '0;
      r_err_count   <= '0;
    end else begin
      r_done_valid  <= w_xfer;
      r_error_valid <= w_err;

      if (w_pop) begin
        r_word     <= w_word_shifted;
        r_byte_cnt <= (r_state == S_IDLE) ? c_bcw'(1) : r_byte_cnt + c_bcw'(1);
      end

      if (w_load_cmd) begin
        r_ch      <= w_ch;
        r_c_addr  <= w_addr;
        r_c_data  <= w_data;
        r_c_valid <= w_ch_onehot;
      end else if (w_xfer || w_err) begin
        r_c_valid <= '0;
      end

      if (w_xfer) begin
        r_done_ch   <= r_ch;
        r_cmd_count <= r_cmd_count + 16'd1;
      end

      if (w_err) begin
        r_error_code <= w_err_code;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  // The pop strobe is combinational so the FWFT head is captured in the very
  // cycle it is acknowledged; gating with rst_n stops the FIFO from losing a
  // byte while the FSM is held in reset.
  assign Rd_En       = w_pop & rst_n;
  assign C_Addr      = r_c_addr;
  assign C_Data      = r_c_data;
  assign C_Valid     = r_c_valid;
  assign Done_Valid  = r_done_valid;
  assign Done_Ch     = r_done_ch;
  assign Error_Valid = r_error_valid;
  assign Error_Code  = r_error_code;
  assign Cmd_Count   = r_cmd_count;
  assign Err_Count   = r_err_count;

endmodule
`default_nettype wire
